hex_score_display: RTL and testbench

Score display controller for the six DE1-SoC HEX digits. It accepts a binary value with a load strobe and converts it to six BCD digits by sequential double-dabble. It then time-shares a single `SevenSegment` decoder instance across the six digits, writing each decoded, active-low pattern into a per-digit output register. It sits between the game score/lives logic and the HEX0–HEX5 board pins, with optional leading-zero blanking.

---
 rtl/hex_score_display.sv | 180 ++++++++++++++++++
 tb/tb_hex_score_display.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/hex_score_display.sv
// Score display for the six DE1-SoC HEX digits: binary-to-BCD by sequential
// double-dabble, then one shared seven-segment decoder scanned across the digits.

module SevenSegment (
  input  logic [3:0] digit,
  input  logic       enable,
  output logic [6:0] seg
);
  always_comb begin
    seg = '1;
    if (enable) begin
      case (digit)
        4'h0: seg = 7'h40;
        4'h1: seg = 7'h79;
        4'h2: seg = 7'h24;
        4'h3: seg = 7'h30;
        4'h4: seg = 7'h19;
        4'h5: seg = 7'h12;
        4'h6: seg = 7'h02;
        4'h7: seg = 7'h78;
        4'h8: seg = 7'h00;
        4'h9: seg = 7'h10;
        4'hA: seg = 7'h08;
        4'hB: seg = 7'h03;
        4'hC: seg = 7'h46;
        4'hD: seg = 7'h21;
        4'hE: seg = 7'h06;
        4'hF: seg = 7'h0E;
        default: seg = '1;
      endcase
    end
  end
endmodule

module hex_score_display #(
  parameter int VALUE_W = 20
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [VALUE_W-1:0] value,
  input  logic               load,
  input  logic               blank_zeros,
  output logic               busy,
  output logic               done,
  output logic [6:0]         hex0,
  output logic [6:0]         hex1,
  output logic [6:0]         hex2,
  output logic [6:0]         hex3,
  output logic [6:0]         hex4,
  output logic [6:0]         hex5
);
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    SCAN    = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [VALUE_W-1:0] MAX_VAL   = VALUE_W'(999999);
  localparam logic [4:0]         LAST_ITER = 5'(VALUE_W - 1);

  state_t             state_q, state_d;
  logic [23:0]        bcd_q, bcd_d;
  logic [VALUE_W-1:0] bin_q, bin_d;
  logic [4:0]         iter_q, iter_d;
  logic [2:0]         idx_q, idx_d;
  logic               blank_q, blank_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [6:0]         hex_q [6];
  logic [6:0]         hex_d [6];

  logic [23:0] bcd_adj;
  logic [3:0]  dec_digit;
  logic        dec_enable;
  logic        upper_zero;
  logic [6:0]  dec_seg;

  SevenSegment u_dec (
    .digit  (dec_digit),
    .enable (dec_enable),
    .seg    (dec_seg)
  );

  // Digit mux for the shared decoder; blanking looks at this and all higher nibbles.
  always_comb begin
    dec_digit  = '0;
    upper_zero = 1'b0;
    for (int unsigned i = 0; i < 6; i++) begin
      if (idx_q == 3'(i)) begin
        dec_digit  = bcd_q[4*i +: 4];
        upper_zero = ((bcd_q >> (4*i)) == '0);
      end
    end
    dec_enable = ~(blank_q & upper_zero & (idx_q != 3'd0));
  end

  always_comb begin
    bcd_adj = bcd_q;
    for (int unsigned i = 0; i < 6; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    state_d = state_q;
    bcd_d   = bcd_q;
    bin_d   = bin_q;
    iter_d  = iter_q;
    idx_d   = idx_q;
    blank_d = blank_q;
    done_d  = 1'b0;
    hex_d   = hex_q;
    case (state_q)
      IDLE: begin
        if (load) begin
          bin_d   = (value > MAX_VAL) ? MAX_VAL : value;
          blank_d = blank_zeros;
          bcd_d   = '0;
          iter_d  = '0;
          state_d = CONVERT;
        end
      end
      CONVERT: begin
        {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
        iter_d = iter_q + 5'd1;
        if (iter_q == LAST_ITER) begin
          idx_d   = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        for (int unsigned i = 0; i < 6; i++) begin
          if (idx_q == 3'(i)) hex_d[i] = dec_seg;
        end
        idx_d = idx_q + 3'd1;
        if (idx_q == 3'd5) begin
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      bcd_q   <= '0;
      bin_q   <= '0;
      iter_q  <= '0;
      idx_q   <= '0;
      blank_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      for (int unsigned i = 0; i < 6; i++) hex_q[i] <= '1;
    end else begin
      state_q <= state_d;
      bcd_q   <= bcd_d;
      bin_q   <= bin_d;
      iter_q  <= iter_d;
      idx_q   <= idx_d;
      blank_q <= blank_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      for (int unsigned i = 0; i < 6; i++) hex_q[i] <= hex_d[i];
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hex0 = hex_q[0];
  assign hex1 = hex_q[1];
  assign hex2 = hex_q[2];
  assign hex3 = hex_q[3];
  assign hex4 = hex_q[4];
  assign hex5 = hex_q[5];
endmodule

// File: tb/tb_hex_score_display.sv
// Directed bench for hex_score_display: latency, digit patterns, blanking,
// clamping, ignored loads, continuous load and mid-operation reset.

module tb_hex_score_display;
  logic        clk = 1'b0;
  logic        reset, load, blank_zeros;
  logic [19:0] value;
  logic        busy, done;
  logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5;

  int checks   = 0;
  int failures = 0;

  hex_score_display #(.VALUE_W(20)) dut (
    .clk         (clk),
    .reset       (reset),
    .value       (value),
    .load        (load),
    .blank_zeros (blank_zeros),
    .busy        (busy),
    .done        (done),
    .hex0        (hex0),
    .hex1        (hex1),
    .hex2        (hex2),
    .hex3        (hex3),
    .hex4        (hex4),
    .hex5        (hex5)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected digits packed as {hex5,hex4,hex3,hex2,hex1,hex0}.
  task automatic check_hex(input string tag, input logic [41:0] exp);
    check({tag, "_hex"}, {22'd0, hex5, hex4, hex3, hex2, hex1, hex0}, {22'd0, exp});
  endtask

  task automatic start(input logic [19:0] v, input logic b);
    @(negedge clk);
    value       = v;
    blank_zeros = b;
    load        = 1'b1;
    @(posedge clk);
    #1;
    load = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!done && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic run_update(input string tag, input logic [19:0] v, input logic b,
                            input logic [41:0] exp);
    int lat;
    start(v, b);
    check({tag, "_busy_on"}, 64'(busy), 64'd1);
    wait_done(lat);
    check({tag, "_lat"}, 64'(lat), 64'd26);
    check_hex(tag, exp);
    @(posedge clk);
    #1;
    check({tag, "_busy_off"}, 64'(busy), 64'd0);
    check({tag, "_done_off"}, 64'(done), 64'd0);
  endtask

  initial begin
    int lat;
    int dones;
    reset       = 1'b1;
    load        = 1'b0;
    value       = '0;
    blank_zeros = 1'b0;
    #1;
    check_hex("reset", {6{7'h7F}});
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    run_update("v123456", 20'd123456, 1'b0, {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02});
    run_update("v42_blank", 20'd42, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h19, 7'h24});
    run_update("v42_noblank", 20'd42, 1'b0, {7'h40, 7'h40, 7'h40, 7'h40, 7'h19, 7'h24});
    run_update("v0_blank", 20'd0, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40});
    run_update("v100005", 20'd100005, 1'b1, {7'h79, 7'h40, 7'h40, 7'h40, 7'h40, 7'h12});
    run_update("v_clamp", 20'd1048575, 1'b0, {6{7'h10}});
    run_update("v999999", 20'd999999, 1'b1, {6{7'h10}});

    // Loads during SCAN/CONVERT are dropped.
    start(20'd111111, 1'b0);
    dones = 0;
    for (int k = 1; k <= 27; k++) begin
      @(negedge clk);
      load  = (k == 5 || k == 26);
      value = 20'd222222;
      @(posedge clk);
      #1;
      if (done) dones++;
      if (k == 5) check("ign_busy_e5", 64'(busy), 64'd1);
    end
    load = 1'b0;
    check("ign_dones", 64'(dones), 64'd1);
    check("ign_busy_off", 64'(busy), 64'd0);
    check_hex("ign", {6{7'h79}});

    // Continuous load restarts every 28 cycles.
    @(negedge clk);
    value       = 20'd5;
    blank_zeros = 1'b1;
    load        = 1'b1;
    wait_done(lat);
    check("cont_first", 64'(done), 64'd1);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!done && lat < 100);
    load = 1'b0;
    check("cont_period", 64'(lat), 64'd28);
    check_hex("cont", {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h12});
    @(posedge clk);
    #1;
    check("cont_busy_off", 64'(busy), 64'd0);

    // Mid-conversion reset aborts and blanks.
    start(20'd888888, 1'b0);
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check_hex("rst_mid", {6{7'h7F}});
    check("rst_mid_busy", 64'(busy), 64'd0);
    dones = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (k == 2) reset = 1'b0;
      if (done) dones++;
    end
    check("rst_mid_nodone", 64'(dones), 64'd0);
    run_update("v7_after_rst", 20'd7, 1'b0, {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h78});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
